// File: rtl/dragonfang_floating_point_pkg.sv
// Floating-point shared definitions: IEEE exception flag vector layout.
// No logic; constants and types only.
// Flag order matches fcsr.fflags {NV,DZ,OF,UF,NX}.
package dragonfang_floating_point_pkg;

  localparam int FFLAGS_WIDTH = 5;

  // Bit positions inside an fflags vector
  localparam int FFLAG_NV = 4;  // invalid operation
  localparam int FFLAG_DZ = 3;  // divide by zero
  localparam int FFLAG_OF = 2;  // overflow
  localparam int FFLAG_UF = 1;  // underflow
  localparam int FFLAG_NX = 0;  // inexact

  typedef logic [FFLAGS_WIDTH-1:0] fflags_t;

endpackage

// File: rtl/dragonfang_pkg.sv
// Core-wide vector unit definitions shared by the vector datapath blocks.
// No logic; constants and types only.
// writeback_entry_t is one queued result headed for the VRF write port.
package dragonfang_pkg;

  localparam int VLEN              = 128;
  localparam int VRF_ADDRESS_WIDTH = 5;

  // One result as it travels from an execution unit to the VRF write port
  typedef struct packed {
    logic [VLEN-1:0]                                       vd;
    logic [VRF_ADDRESS_WIDTH-1:0]                          vd_address;
    logic [dragonfang_floating_point_pkg::FFLAGS_WIDTH-1:0] fflags;
  } writeback_entry_t;

endpackage

// File: rtl/vector_floating_point_writeback_queue.sv
// Purpose: in-order result queue between the vector sqrt unit and the VRF write port, with sticky fflags.
// Latency: one cycle from push to out_valid on an empty queue; head is first-word-fall-through.
// Backpressure: in_ready depends only on occupancy (count < DEPTH); a full queue refuses a push even if it pops.
module vector_floating_point_writeback_queue
  import dragonfang_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = VRF_ADDRESS_WIDTH,
  parameter int FFLAGS_WIDTH  = dragonfang_floating_point_pkg::FFLAGS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VLEN-1:0]            in_vd,
  input  logic [ADDRESS_WIDTH-1:0]   in_vd_address,
  input  logic [FFLAGS_WIDTH-1:0]    in_fflags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VLEN-1:0]            out_vd,
  output logic [ADDRESS_WIDTH-1:0]   out_vd_address,
  output logic [FFLAGS_WIDTH-1:0]    out_fflags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [FFLAGS_WIDTH-1:0]    fflags_accumulated,
  input  logic                       fflags_clear
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Payload storage is deliberately left without reset; only the control state is cleared.
  writeback_entry_t  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  writeback_entry_t  in_entry;
  writeback_entry_t  head_entry;
  logic              push;
  logic              pop;

  // Handshake decode; ready/valid come only from the registered count.
  always_comb begin
    in_ready  = (count < FULL_COUNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Pack the incoming result and unpack the head entry for the VRF port.
  always_comb begin
    in_entry.vd         = in_vd;
    in_entry.vd_address = in_vd_address;
    in_entry.fflags     = in_fflags;
    head_entry          = mem[rd_ptr];
    out_vd              = head_entry.vd;
    out_vd_address      = head_entry.vd_address;
    out_fflags          = head_entry.fflags;
  end

  // Write the accepted result into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers wrap by natural rollover; occupancy moves only on push-xor-pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky flags collect on retirement; a clear coinciding with a pop keeps that pop's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_accumulated <= '0;
    end else if (pop) begin
      if (fflags_clear) begin
        fflags_accumulated <= out_fflags;
      end else begin
        fflags_accumulated <= fflags_accumulated | out_fflags;
      end
    end else if (fflags_clear) begin
      fflags_accumulated <= '0;
    end
  end

`ifndef SYNTHESIS
  // A full queue must never accept a push.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == FULL_COUNT)));

  // An empty queue must never retire an entry.
  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == '0)));

  // A stalled head must hold still until the VRF takes it.
  a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_vd)
                                   && $stable(out_vd_address) && $stable(out_fflags)));
`endif

endmodule

// File: tb/tb_vector_floating_point_writeback_queue.sv
module tb_vector_floating_point_writeback_queue;
  import dragonfang_floating_point_pkg::*;

  localparam int DEPTH = 4;
  localparam int VL    = 128;
  localparam int AW    = 5;
  localparam int FW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VL-1:0] in_vd;
  logic [AW-1:0] in_vd_address;
  logic [FW-1:0] in_fflags;
  logic          out_valid;
  logic          out_ready;
  logic [VL-1:0] out_vd;
  logic [AW-1:0] out_vd_address;
  logic [FW-1:0] out_fflags;
  logic [2:0]    count;
  logic [FW-1:0] fflags_accumulated;
  logic          fflags_clear;

  always #5 clk = ~clk;

  vector_floating_point_writeback_queue #(
    .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .FFLAGS_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vd(in_vd),
    .in_vd_address(in_vd_address), .in_fflags(in_fflags),
    .out_valid(out_valid), .out_ready(out_ready), .out_vd(out_vd),
    .out_vd_address(out_vd_address), .out_fflags(out_fflags),
    .count(count), .fflags_accumulated(fflags_accumulated),
    .fflags_clear(fflags_clear)
  );

  // Reference model: an ordered list of pending results plus the sticky flag word
  typedef struct {
    logic [VL-1:0] vd;
    logic [AW-1:0] a;
    logic [FW-1:0] f;
  } ent_t;

  ent_t          mq[$];
  logic [FW-1:0] macc = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [VL-1:0] got, input logic [VL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update at each clock edge, emptied whenever reset is low
  always @(posedge clk or negedge rst_n) begin
    ent_t h;
    ent_t n;
    bit   do_pop;
    bit   do_push;
    if (!rst_n) begin
      mq.delete();
      macc = '0;
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        h    = mq.pop_front();
        macc = fflags_clear ? h.f : (macc | h.f);
      end else if (fflags_clear) begin
        macc = '0;
      end
      if (do_push) begin
        n.vd = in_vd;
        n.a  = in_vd_address;
        n.f  = in_fflags;
        mq.push_back(n);
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  always @(negedge clk) begin
    chk("m_count", VL'(count), VL'(mq.size()));
    chk("m_in_ready", VL'(in_ready), VL'(mq.size() < DEPTH));
    chk("m_out_valid", VL'(out_valid), VL'(mq.size() != 0));
    chk("m_acc", VL'(fflags_accumulated), VL'(macc));
    if (mq.size() != 0) begin
      chk("m_head_vd", out_vd, mq[0].vd);
      chk("m_head_addr", VL'(out_vd_address), VL'(mq[0].a));
      chk("m_head_ff", VL'(out_fflags), VL'(mq[0].f));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [VL-1:0] vd, input logic [AW-1:0] a,
                       input logic [FW-1:0] f, input logic ordy, input logic clr);
    in_valid      = v;
    in_vd         = vd;
    in_vd_address = a;
    in_fflags     = f;
    out_ready     = ordy;
    fflags_clear  = clr;
  endtask

  initial begin
    int n;
    logic [FW-1:0] nv;
    logic [FW-1:0] nx;
    nv = '0;
    nx = '0;
    nv[FFLAG_NV] = 1'b1;
    nx[FFLAG_NX] = 1'b1;

    // 1. Reset values
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_count", VL'(count), 0);
    chk("rst_out_valid", VL'(out_valid), 0);
    chk("rst_in_ready", VL'(in_ready), 1);
    chk("rst_acc", VL'(fflags_accumulated), 0);
    #20;
    rst_n = 1'b1;
    cyc();

    // 2. Push one result with the VRF stalled, then drain it
    drive(1'b1, {16{8'hA5}}, 5'd3, 5'b00001, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("t2_out_valid", VL'(out_valid), 1);
    chk("t2_addr", VL'(out_vd_address), 3);
    chk("t2_vd", out_vd, {16{8'hA5}});
    chk("t2_count", VL'(count), 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t2_count_after", VL'(count), 0);
    chk("t2_acc", VL'(fflags_accumulated), 5'b00001);
    chk("t2_empty", VL'(out_valid), 0);

    // 3. Fill to full, refuse a fifth, drain in order across the pointer wrap
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, VL'(i * 32'h1111), AW'(i), 5'b00000, 1'b0, 1'b0);
      cyc();
    end
    in_valid = 1'b0;
    chk("t3_full_count", VL'(count), 4);
    chk("t3_full_ready", VL'(in_ready), 0);
    drive(1'b1, VL'(32'hDEAD), 5'd5, 5'b11111, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("t3_reject_count", VL'(count), 4);
    chk("t3_reject_head", VL'(out_vd_address), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", VL'(out_vd_address), VL'(i));
      cyc();
    end
    out_ready = 1'b0;
    chk("t3_drained", VL'(count), 0);
    chk("t3_acc", VL'(fflags_accumulated), 5'b00001);

    // 4. Steady push+pop at occupancy 2
    drive(1'b1, VL'(32'hA0), 5'd10, 5'b00010, 1'b0, 1'b0);
    cyc();
    drive(1'b1, VL'(32'hB0), 5'd11, 5'b00100, 1'b0, 1'b0);
    cyc();
    chk("t4_pre_count", VL'(count), 2);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()},
            AW'($urandom_range(0, 31)), FW'($urandom_range(0, 31)), 1'b1,
            ($urandom_range(0, 3) == 0));
      cyc();
      chk("t4_count_steady", VL'(count), 2);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    n = 0;
    while (count != 0 && n < 10) begin
      cyc();
      n++;
    end
    chk("t4_drain", VL'(count), 0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cyc();
    fflags_clear = 1'b0;
    chk("t4_cleared", VL'(fflags_accumulated), 0);

    // 5. Flags: retire NV, then NX together with a clear, then idle clear
    drive(1'b1, VL'(32'h1), 5'd20, nv, 1'b0, 1'b0);
    cyc();
    drive(1'b1, VL'(32'h2), 5'd21, nx, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc();
    chk("t5_acc_nv", VL'(fflags_accumulated), 5'b10000);
    fflags_clear = 1'b1;
    cyc();
    chk("t5_acc_nx_clear", VL'(fflags_accumulated), 5'b00001);
    out_ready = 1'b0;
    cyc();
    fflags_clear = 1'b0;
    chk("t5_acc_idle_clear", VL'(fflags_accumulated), 0);

    // 6. Async reset with three entries queued mid-drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, VL'(32'h700 + i), AW'(24 + i), 5'b01000, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc();
    out_ready = 1'b0;
    chk("t6_pre_count", VL'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", VL'(out_valid), 0);
    chk("t6_rst_count", VL'(count), 0);
    chk("t6_rst_ready", VL'(in_ready), 1);
    chk("t6_rst_acc", VL'(fflags_accumulated), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_post_count", VL'(count), 0);
    chk("t6_post_valid", VL'(out_valid), 0);
    drive(1'b1, VL'(32'hBEEF), 5'd31, 5'b00100, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("t6_new_addr", VL'(out_vd_address), 31);
    chk("t6_new_vd", out_vd, VL'(32'hBEEF));
    chk("t6_new_count", VL'(count), 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t6_final_count", VL'(count), 0);
    chk("t6_final_acc", VL'(fflags_accumulated), 5'b00100);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
